// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared types and gate lengths for the frequency gate sequencer
package counters_pkg;

   typedef enum logic [1:0] {
      R1MS   = 2'd0,
      R10MS  = 2'd1,
      R100MS = 2'd2,
      R1S    = 2'd3
   } range_t;

   localparam int unsigned GATE_MS [4] = '{1, 10, 100, 1000};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_GATE    = 3'd2,
      S_EVAL    = 3'd3,
      S_PUBLISH = 3'd4
   } state_t;

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - millisecond down-counter that times one measurement gate
module gate_timer
   import counters_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  range_t range_i,
   input  logic   tick,
   output logic   done
);

   logic [9:0] ms_q, ms_d;

   always_comb begin
      ms_d = ms_q;
      if (load) begin
         ms_d = 10'(GATE_MS[range_i] - 1);
      end else if (tick && (ms_q != 10'd0)) begin
         ms_d = ms_q - 10'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ms_q <= 10'd0;
      end else begin
         ms_q <= ms_d;
      end
   end

   // The tick that finds the counter at zero is the Nth tick after the gate opened.
   assign done = tick && !load && (ms_q == 10'd0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - auto-ranging gated event counter; FREQ_GATE_CTRL_HOLD_EN adds a publish hold input
module freq_gate_ctrl
   import counters_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int LOW_THRESH = 6000,
   parameter int RANGE_INIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce1ms,
   input  logic             evt,
   input  logic             run,
`ifdef FREQ_GATE_CTRL_HOLD_EN
   input  logic             hold,
`endif
   output logic [WIDTH-1:0] count,
   output logic [1:0]       range,
   output logic             ovf,
   output logic             valid,
   output logic             busy
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] LOW_T   = WIDTH'(LOW_THRESH);
   localparam range_t           RNG_RST = range_t'(2'(RANGE_INIT));

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             ovf_int_q, ovf_int_d;
   range_t           rng_q, rng_d;
   logic [WIDTH-1:0] pub_count_q, pub_count_d;
   range_t           pub_range_q, pub_range_d;
   logic             pub_ovf_q, pub_ovf_d;
   logic             valid_q, valid_d;
   logic             timer_load;
   logic             timer_done;
   logic             hold_w;

`ifdef FREQ_GATE_CTRL_HOLD_EN
   assign hold_w = hold;
`else
   assign hold_w = 1'b0;
`endif

   gate_timer u_gate_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .range_i (rng_q),
      .tick    (ce1ms),
      .done    (timer_done)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ovf_int_d   = ovf_int_q;
      rng_d       = rng_q;
      pub_count_d = pub_count_q;
      pub_range_d = pub_range_q;
      pub_ovf_d   = pub_ovf_q;
      valid_d     = 1'b0;
      timer_load  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_ARM;
         end
         S_ARM: begin
            if (!run) begin
               state_d = S_IDLE;
            end else if (ce1ms) begin
               state_d    = S_GATE;
               cnt_d      = '0;
               ovf_int_d  = 1'b0;
               timer_load = 1'b1;
            end
         end
         S_GATE: begin
            if (!run) begin
               state_d = S_IDLE;
            end else begin
               if (evt) begin
                  if (cnt_q == CNT_MAX) ovf_int_d = 1'b1;
                  else                  cnt_d     = cnt_q + 1'b1;
               end
               if (timer_done) state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            // Outputs load on the way into PUBLISH so valid and the new count coincide.
            if (!run) begin
               state_d = S_IDLE;
            end else if (ovf_int_q && (rng_q != R1MS)) begin
               rng_d   = range_t'(2'(rng_q - 2'd1));
               state_d = S_ARM;
            end else begin
               state_d = S_PUBLISH;
               if (!hold_w) begin
                  pub_count_d = cnt_q;
                  pub_range_d = rng_q;
                  pub_ovf_d   = ovf_int_q;
                  valid_d     = 1'b1;
               end
               if ((cnt_q < LOW_T) && (rng_q != R1S)) rng_d = range_t'(2'(rng_q + 2'd1));
            end
         end
         S_PUBLISH: begin
            state_d = run ? S_ARM : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ovf_int_q   <= 1'b0;
         rng_q       <= RNG_RST;
         pub_count_q <= '0;
         pub_range_q <= RNG_RST;
         pub_ovf_q   <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ovf_int_q   <= ovf_int_d;
         rng_q       <= rng_d;
         pub_count_q <= pub_count_d;
         pub_range_q <= pub_range_d;
         pub_ovf_q   <= pub_ovf_d;
         valid_q     <= valid_d;
      end
   end

   assign count = pub_count_q;
   assign range = pub_range_q;
   assign ovf   = pub_ovf_q;
   assign valid = valid_q;
   assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - randomized bench for freq_gate_ctrl against a gate-level behavioural model
module tb_freq_gate_ctrl;

   localparam int W    = 8;
   localparam int LT   = 20;
   localparam int RI   = 3;
   localparam int MAXV = (1 << W) - 1;
`ifdef FREQ_GATE_CTRL_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   localparam int P_IDLE   = 0;
   localparam int P_WAIT   = 1;
   localparam int P_OPEN   = 2;
   localparam int P_CLOSED = 3;
   localparam int P_SHOW   = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         ce1ms;
   logic         evt;
   logic         run;
   logic         hold;
   logic [W-1:0] count;
   logic [1:0]   range;
   logic         ovf;
   logic         valid;
   logic         busy;

   int tests = 0;
   int fails = 0;

   int ph;
   int m_rng;
   int m_n;
   int m_ticks;
   int e_count;
   int e_range;
   int e_ovf;
   int e_valid;
   int e_busy;

   always #5 clk = ~clk;

   freq_gate_ctrl #(
      .WIDTH      (W),
      .LOW_THRESH (LT),
      .RANGE_INIT (RI)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .ce1ms (ce1ms),
      .evt   (evt),
      .run   (run),
`ifdef FREQ_GATE_CTRL_HOLD_EN
      .hold  (hold),
`endif
      .count (count),
      .range (range),
      .ovf   (ovf),
      .valid (valid),
      .busy  (busy)
   );

   function automatic int gate_ms(int r);
      int g = 1;
      for (int i = 0; i < r; i++) g = g * 10;
      return g;
   endfunction

   // Model: a gate counts raw events as an unbounded integer and is judged when it closes.
   task automatic model_step();
      bit h;
      int v;
      h = HOLD_EN && hold;
      e_valid = 0;
      if (rst) begin
         ph      = P_IDLE;
         m_rng   = RI;
         e_count = 0;
         e_range = RI;
         e_ovf   = 0;
      end else begin
         case (ph)
            P_IDLE: if (run) ph = P_WAIT;
            P_WAIT: begin
               if (!run) ph = P_IDLE;
               else if (ce1ms) begin
                  ph      = P_OPEN;
                  m_n     = 0;
                  m_ticks = 0;
               end
            end
            P_OPEN: begin
               if (!run) ph = P_IDLE;
               else begin
                  if (evt) m_n++;
                  if (ce1ms) m_ticks++;
                  if (m_ticks == gate_ms(m_rng)) ph = P_CLOSED;
               end
            end
            P_CLOSED: begin
               if (!run) ph = P_IDLE;
               else if ((m_n > MAXV) && (m_rng > 0)) begin
                  m_rng--;
                  ph = P_WAIT;
               end else begin
                  v = (m_n > MAXV) ? MAXV : m_n;
                  if (!h) begin
                     e_count = v;
                     e_range = m_rng;
                     e_ovf   = (m_n > MAXV) ? 1 : 0;
                     e_valid = 1;
                  end
                  if ((v < LT) && (m_rng < 3)) m_rng++;
                  ph = P_SHOW;
               end
            end
            default: ph = run ? P_WAIT : P_IDLE;
         endcase
      end
      e_busy = (ph != P_IDLE) ? 1 : 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle(input int p_ce, input int p_evt);
      ce1ms = ($urandom_range(999) < p_ce);
      evt   = ($urandom_range(999) < p_evt);
      @(posedge clk);
      model_step();
      #1;
      chk("count", 32'(count), e_count);
      chk("range", 32'(range), e_range);
      chk("ovf",   32'(ovf),   e_ovf);
      chk("valid", 32'(valid), e_valid);
      chk("busy",  32'(busy),  e_busy);
   endtask

   // Probabilities are per mille per cycle.
   task automatic seg(input int n, input int p_ce, input int p_evt, input int p_flip, input int p_hold);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(999) < p_flip) run = ~run;
         hold = ($urandom_range(999) < p_hold);
         cycle(p_ce, p_evt);
      end
   endtask

   initial begin
      rst   = 1'b1;
      run   = 1'b0;
      ce1ms = 1'b0;
      evt   = 1'b0;
      hold  = 1'b0;
      ph    = P_IDLE;
      m_rng = RI;
      m_n   = 0;
      m_ticks = 0;
      repeat (3) cycle(0, 0);
      rst = 1'b0;

      seg(300, 50, 300, 0, 0);
      run = 1'b1;
      seg(1100, 1000, 50, 0, 0);
      seg(1500, 1000, 600, 0, 0);
      seg(3000, 300, 1000, 0, 0);
      seg(8000, 3, 1000, 0, 0);
      seg(4000, 1000, 2, 0, 0);
      seg(4000, 200, 300, 20, 0);

      run = 1'b1;
      seg(150, 1000, 100, 0, 0);
      rst = 1'b1;
      cycle(1000, 1000);
      rst = 1'b0;

      run = 1'b1;
      seg(1200, 1000, 40, 0, 0);
      seg(4000, 400, 200, 5, 300);
      run = 1'b0;
      seg(20, 500, 500, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
